// File: rtl/rf_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rf_port_ctrl
// Brief    : Register-file write port / read port B arbiter between the core
//            pipeline and the debug module, with a post-reset clear sequence.
// Revision : 1.0 - initial release
// ============================================================================
module rf_port_ctrl #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            core_halted_i,
  output logic            core_stall_o,
  output logic            init_done_o,
  input  logic            wb_we_i,
  input  logic [AW-1:0]   wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic [AW-1:0]   core_rs2_i,
  input  logic            dbg_valid_i,
  output logic            dbg_ready_o,
  input  logic            dbg_we_i,
  input  logic [AW-1:0]   dbg_addr_i,
  input  logic [XLEN-1:0] dbg_wdata_i,
  output logic            dbg_rvalid_o,
  output logic [XLEN-1:0] dbg_rdata_o,
  output logic            rf_we_o,
  output logic [AW-1:0]   rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o,
  output logic [AW-1:0]   rf_raddr_b_o,
  input  logic [XLEN-1:0] rf_rdata_b_i
);

  typedef enum logic [1:0] {
    S_CLEAR   = 2'd0,
    S_IDLE    = 2'd1,
    S_DBG_RD  = 2'd2,
    S_DBG_RSP = 2'd3
  } state_t;

  localparam logic [AW-1:0] C_LAST_REG = '1;

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic            init_done_q, init_done_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] dbg_rdata_q, dbg_rdata_d;
  logic            w_core_wr;

  assign w_core_wr = wb_we_i && (wb_rd_i != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_CLEAR;
      clr_cnt_q   <= AW'(1);
      init_done_q <= 1'b0;
      rd_addr_q   <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
      rd_addr_q   <= rd_addr_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    init_done_d  = init_done_q;
    rd_addr_d    = rd_addr_q;
    dbg_rdata_d  = dbg_rdata_q;
    rf_we_o      = 1'b0;
    rf_waddr_o   = '0;
    rf_wdata_o   = '0;
    rf_raddr_b_o = core_rs2_i;
    dbg_ready_o  = 1'b0;

    // The core owns the write port in every state except the clear sequence.
    if (state_q != S_CLEAR && w_core_wr) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = wb_rd_i;
      rf_wdata_o = wb_data_i;
    end

    case (state_q)
      S_CLEAR: begin
        rf_we_o    = 1'b1;
        rf_waddr_o = clr_cnt_q;
        rf_wdata_o = '0;
        clr_cnt_d  = clr_cnt_q + AW'(1);
        if (clr_cnt_q == C_LAST_REG) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end
      end
      S_IDLE: begin
        dbg_ready_o = dbg_valid_i && core_halted_i && !w_core_wr;
        if (dbg_ready_o) begin
          if (dbg_we_i) begin
            if (dbg_addr_i != '0) begin
              rf_we_o    = 1'b1;
              rf_waddr_o = dbg_addr_i;
              rf_wdata_o = dbg_wdata_i;
            end
          end else begin
            rf_raddr_b_o = dbg_addr_i;
            rd_addr_d    = dbg_addr_i;
            state_d      = S_DBG_RD;
          end
        end
      end
      S_DBG_RD: begin
        // x0 is forced to zero here regardless of what the array returns.
        dbg_rdata_d = (rd_addr_q == '0) ? '0 : rf_rdata_b_i;
        state_d     = S_DBG_RSP;
      end
      S_DBG_RSP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_CLEAR;
      end
    endcase
  end

  assign core_stall_o = ~init_done_q;
  assign init_done_o  = init_done_q;
  assign dbg_rvalid_o = (state_q == S_DBG_RSP);
  assign dbg_rdata_o  = dbg_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_port_ctrl
// Brief    : Randomized scoreboard bench for rf_port_ctrl with a reg_file model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_port_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_halted = 1'b0;
  logic        core_stall, init_done;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic [4:0]  core_rs2 = '0;
  logic        dbg_valid = 1'b0;
  logic        dbg_ready;
  logic        dbg_we = 1'b0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr, rf_raddr_b;
  logic [31:0] rf_wdata, rf_rdata_b;

  rf_port_ctrl #(.XLEN(32), .AW(5)) dut (
    .clk(clk), .rst(rst), .core_halted_i(core_halted),
    .core_stall_o(core_stall), .init_done_o(init_done),
    .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_data_i(wb_data), .core_rs2_i(core_rs2),
    .dbg_valid_i(dbg_valid), .dbg_ready_o(dbg_ready), .dbg_we_i(dbg_we),
    .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .rf_raddr_b_o(rf_raddr_b), .rf_rdata_b_i(rf_rdata_b)
  );

  always #5 clk = ~clk;

  // Register array behind the ports; x0 reads back garbage so forcing is visible.
  logic [31:0] rf_mem [32];
  always @(posedge clk) begin
    if (rf_we && rf_waddr != 5'd0) rf_mem[rf_waddr] <= rf_wdata;
    if (rf_raddr_b == 5'd0)                       rf_rdata_b <= 32'hBAD0_0BAD;
    else if (rf_we && rf_waddr == rf_raddr_b)     rf_rdata_b <= rf_wdata;
    else                                          rf_rdata_b <= rf_mem[rf_raddr_b];
  end

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         wq[$];
  logic [31:0] rq[$];
  logic [31:0] mem_m [32];
  int          clr_left = 31;
  int          rd_busy  = 0;
  int          n_tests  = 0;
  int          n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or read response.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rf_we) begin
          if (wq.size() == 0) chk("unexpected_write", {27'd0, rf_waddr}, 32'hFFFF_FFFF);
          else begin
            wr_t w;
            w = wq.pop_front();
            chk("wr_addr", {27'd0, rf_waddr}, {27'd0, w.a});
            chk("wr_data", rf_wdata, w.d);
          end
        end
        if (dbg_rvalid) begin
          if (rq.size() == 0) chk("unexpected_rvalid", 32'd1, 32'd0);
          else chk("dbg_rdata", dbg_rdata, rq.pop_front());
        end
      end
    end
  end

  task automatic step(input logic h, input logic we, input logic [4:0] rd,
                      input logic [31:0] wd, input logic [4:0] rs2,
                      input logic v, input logic dwe, input logic [4:0] da,
                      input logic [31:0] dwd);
    logic       exp_rdy, cw, do_w;
    logic [4:0] exp_rb;
    wr_t        w;
    core_halted = h; wb_we = we; wb_rd = rd; wb_data = wd; core_rs2 = rs2;
    dbg_valid = v; dbg_we = dwe; dbg_addr = da; dbg_wdata = dwd;
    exp_rdy = 1'b0; do_w = 1'b0; exp_rb = rs2; w.a = '0; w.d = '0;
    if (clr_left > 0) begin
      do_w = 1'b1; w.a = 5'(32 - clr_left); w.d = '0;
    end else begin
      cw = we && (rd != 5'd0);
      if (cw) begin do_w = 1'b1; w.a = rd; w.d = wd; end
      if (rd_busy == 0) begin
        exp_rdy = v && h && !cw;
        if (exp_rdy && dwe && da != 5'd0) begin do_w = 1'b1; w.a = da; w.d = dwd; end
        if (exp_rdy && !dwe) begin
          rq.push_back(da == 5'd0 ? 32'd0 : mem_m[da]);
          exp_rb = da;
        end
      end
    end
    if (do_w) wq.push_back(w);
    @(negedge clk);
    chk("dbg_ready", {31'd0, dbg_ready}, {31'd0, exp_rdy});
    chk("core_stall", {31'd0, core_stall}, {31'd0, clr_left > 0});
    chk("init_done", {31'd0, init_done}, {31'd0, clr_left == 0});
    chk("dbg_rvalid", {31'd0, dbg_rvalid}, {31'd0, (clr_left == 0) && (rd_busy == 1)});
    chk("raddr_b", {27'd0, rf_raddr_b}, {27'd0, exp_rb});
    @(posedge clk);
    if (do_w) mem_m[w.a] = w.d;
    if (clr_left > 0) clr_left--;
    else if (rd_busy > 0) rd_busy--;
    else if (exp_rdy && !dwe) rd_busy = 2;
    #1;
  endtask

  task automatic rand_step();
    step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
         ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
         $urandom, 5'($urandom_range(0, 31)),
         $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
         5'($urandom_range(0, 9)), $urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 5'd0, 32'd0, 5'($urandom_range(0, 31)),
                                     1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; wb_we = 1'b0; dbg_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_core_stall", {31'd0, core_stall}, 32'd1);
    chk("rst_dbg_ready", {31'd0, dbg_ready}, 32'd0);
    chk("rst_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    chk("rst_rf_waddr", {27'd0, rf_waddr}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    clr_left = 31; rd_busy = 0;
    rq.delete(); wq.delete();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem_m[i] = 32'd0;
    do_reset(2);
    chk("rst_dbg_rdata", dbg_rdata, 32'd0);
    for (int i = 0; i < 31; i++) rand_step();
    // Core writeback: real register, then x0.
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 1'b0, 1'b0, 5'd0, 32'd0);
    step(1'b0, 1'b1, 5'd0, 32'hCAFEF00D, 5'd2, 1'b0, 1'b0, 5'd0, 32'd0);
    // Debug write then read of x7, then read of x0.
    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 1'b1, 1'b1, 5'd7, 32'h12345678);
    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 1'b1, 1'b0, 5'd7, 32'd0);
    idle(2);
    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'd0);
    idle(2);
    // Core and debug write collide; debug retries once core releases.
    step(1'b1, 1'b1, 5'd3, 32'hA5A5_0003, 5'd0, 1'b1, 1'b1, 5'd4, 32'h0000_0444);
    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 1'b1, 1'b1, 5'd4, 32'h0000_0444);
    // Write-then-read in consecutive cycles.
    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 1'b1, 1'b1, 5'd9, 32'h9999_0009);
    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 1'b1, 1'b0, 5'd9, 32'd0);
    idle(2);
    for (int a = 3; a <= 5; a++) begin
      step(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 1'b1, 1'b0, 5'(a), 32'd0);
      idle(2);
    end
    // Not halted: requests must never be accepted.
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 1'b1, $urandom_range(0, 1) == 1, 5'd6, $urandom);
    for (int i = 0; i < 400; i++) rand_step();
    // Reset in the middle of the clear sequence.
    do_reset(1);
    for (int i = 0; i < 9; i++) rand_step();
    do_reset(1);
    for (int i = 0; i < 31; i++) rand_step();
    for (int i = 0; i < 60; i++) rand_step();
    // Reset while a read sits in DBG_RD: its response must never appear.
    idle(3);
    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 1'b1, 1'b0, 5'd5, 32'd0);
    do_reset(1);
    for (int i = 0; i < 31; i++) rand_step();
    for (int i = 0; i < 150; i++) rand_step();
    idle(3);
    chk("write_queue_drained", wq.size(), 32'd0);
    chk("read_queue_drained", rq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
